// File: rtl/tdm_demux_1_2_pkg.sv
// Shared definitions for the two-channel TDM demultiplexer.
package tdm_demux_1_2_pkg;

   localparam int unsigned W_DEF = 8;

   typedef enum logic {
      HUNT  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width of the in-frame bit index for a given word width.
   function automatic int unsigned idx_bits(input int unsigned w);
      return (2 * w > 1) ? $clog2(2 * w) : 1;
   endfunction

endpackage

// File: rtl/tdm_demux_1_2_if.sv
// Serial link input and per-channel word output bundle.
interface tdm_demux_1_2_if
   import tdm_demux_1_2_pkg::*;
#(
   parameter int unsigned W = W_DEF
) ();

   logic         din;
   logic         din_vld;
   logic         fs;
   logic [W-1:0] oa;
   logic [W-1:0] ob;
   logic         o_vld;
   logic         err;

   modport master (
      output din, din_vld, fs,
      input  oa, ob, o_vld, err
   );

   modport slave (
      input  din, din_vld, fs,
      output oa, ob, o_vld, err
   );

endinterface

// File: rtl/tdm_demux_1_2_sipo_w.sv
// W-bit serial-in parallel-out shift register, MSB arrives first.
module sipo_w
   import tdm_demux_1_2_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic         d,
   output logic [W-1:0] q
);

   // Shift toward MSB so the first bit received ends up in q[W-1].
   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= {q[W-2:0], d};
      end
   end

endmodule

// File: rtl/tdm_demux_1_2.sv
// Two-channel bit-interleaved TDM demultiplexer with frame-sync hunt.
module tdm_demux_1_2
   import tdm_demux_1_2_pkg::*;
#(
   parameter int unsigned W = W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   tdm_demux_1_2_if.slave  bus
);

   localparam int unsigned   IW       = idx_bits(W);
   localparam logic [IW-1:0] IDX_LAST = IW'(2 * W - 1);

   state_t        state;
   logic [IW-1:0] idx;
   logic [W-1:0]  a_q;
   logic [W-1:0]  b_q;
   logic [W-1:0]  oa_q;
   logic [W-1:0]  ob_q;
   logic          o_vld_q;
   logic          err_q;
   logic          sh_a;
   logic          sh_b;

   // Steer accepted bits: fs always starts channel A, otherwise idx parity picks the channel.
   always_comb begin
      sh_a = 1'b0;
      sh_b = 1'b0;
      if (bus.din_vld) begin
         if (state == HUNT) begin
            sh_a = bus.fs;
         end else begin
            sh_a = bus.fs | ~idx[0];
            sh_b = ~bus.fs & idx[0];
         end
      end
   end

   sipo_w #(.W(W)) u_sipo_a (
      .clk (clk),
      .clr (rst),
      .en  (sh_a),
      .d   (bus.din),
      .q   (a_q)
   );

   sipo_w #(.W(W)) u_sipo_b (
      .clk (clk),
      .clr (rst),
      .en  (sh_b),
      .d   (bus.din),
      .q   (b_q)
   );

   // Frame control, bit index and output word registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HUNT;
         idx     <= '0;
         oa_q    <= '0;
         ob_q    <= '0;
         o_vld_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         o_vld_q <= 1'b0;
         err_q   <= 1'b0;
         if (bus.din_vld) begin
            case (state)
               HUNT: begin
                  if (bus.fs) begin
                     state <= SHIFT;
                     idx   <= IW'(1);
                  end
               end
               SHIFT: begin
                  if (bus.fs) begin
                     // Unexpected sync: drop the partial frame, this bit is the new idx 0.
                     err_q <= 1'b1;
                     idx   <= IW'(1);
                  end else if (idx == IDX_LAST) begin
                     // Last bit belongs to channel B; merge it straight into the output word.
                     oa_q    <= a_q;
                     ob_q    <= {b_q[W-2:0], bus.din};
                     o_vld_q <= 1'b1;
                     state   <= HUNT;
                     idx     <= '0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
               default: begin
                  state <= HUNT;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.oa    = oa_q;
   assign bus.ob    = ob_q;
   assign bus.o_vld = o_vld_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_tdm_demux_1_2.sv
// Directed bench for tdm_demux_1_2 with W=8.
module tb_tdm_demux_1_2;
   import tdm_demux_1_2_pkg::*;

   localparam int unsigned W = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   tdm_demux_1_2_if #(.W(W)) bus ();

   tdm_demux_1_2 #(.W(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total   = 0;
   int bad     = 0;
   int cyc     = 0;
   int n_vld   = 0;
   int n_err   = 0;
   int vld_cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One clock: drive on the falling edge, observe #1 after the rising edge.
   task automatic step(input logic d, input logic v, input logic f);
      @(negedge clk);
      bus.din     = d;
      bus.din_vld = v;
      bus.fs      = f;
      @(posedge clk);
      #1;
      cyc++;
      if (bus.o_vld === 1'b1) begin
         n_vld++;
         vld_cyc = cyc;
      end
      if (bus.err === 1'b1) begin
         n_err++;
      end
   endtask

   // Bit carried at frame index i: even -> A, odd -> B, MSB first.
   function automatic logic fbit(input logic [7:0] a, input logic [7:0] b, input int i);
      logic [7:0] wa;
      logic [7:0] wb;
      wa = a;
      wb = b;
      return (i % 2 == 0) ? wa[7 - i / 2] : wb[7 - i / 2];
   endfunction

   // Send frame indices lo..hi; fs accompanies index 0 when it is included.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         step(fbit(a, b, i), 1'b1, 1'(i == 0));
      end
   endtask

   int v0;
   int e0;
   int s0;
   int c1;

   initial begin
      rst         = 1'b1;
      bus.din     = 1'b0;
      bus.din_vld = 1'b0;
      bus.fs      = 1'b0;
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk("rst_oa", 32'(bus.oa), 32'h0);
      chk("rst_ob", 32'(bus.ob), 32'h0);
      chk("rst_vld", 32'(bus.o_vld), 32'h0);
      chk("rst_err", 32'(bus.err), 32'h0);
      rst = 1'b0;

      // Basic frame A=A5 B=3C.
      v0 = n_vld;
      e0 = n_err;
      send(8'hA5, 8'h3C, 0, 14);
      chk("t1_early_vld", 32'(n_vld - v0), 32'd0);
      send(8'hA5, 8'h3C, 15, 15);
      chk("t1_vld", 32'(bus.o_vld), 32'h1);
      chk("t1_oa", 32'(bus.oa), 32'hA5);
      chk("t1_ob", 32'(bus.ob), 32'h3C);
      chk("t1_err", 32'(n_err - e0), 32'd0);
      step(1'b0, 1'b0, 1'b0);
      chk("t1_pulse", 32'(bus.o_vld), 32'h0);

      // Same frame with a 3-cycle stall after idx 5; fs during stall must be ignored.
      v0 = n_vld;
      e0 = n_err;
      s0 = cyc;
      send(8'hA5, 8'h3C, 0, 5);
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b1);
      send(8'hA5, 8'h3C, 6, 15);
      chk("t2_oa", 32'(bus.oa), 32'hA5);
      chk("t2_ob", 32'(bus.ob), 32'h3C);
      chk("t2_nvld", 32'(n_vld - v0), 32'd1);
      chk("t2_lat", 32'(vld_cyc - s0), 32'd19);
      chk("t2_err", 32'(n_err - e0), 32'd0);

      // Back-to-back frames with no gap.
      v0 = n_vld;
      send(8'h01, 8'h80, 0, 15);
      c1 = vld_cyc;
      chk("t3_oa1", 32'(bus.oa), 32'h01);
      chk("t3_ob1", 32'(bus.ob), 32'h80);
      send(8'hFF, 8'h00, 0, 15);
      chk("t3_gap", 32'(vld_cyc - c1), 32'd16);
      chk("t3_oa2", 32'(bus.oa), 32'hFF);
      chk("t3_ob2", 32'(bus.ob), 32'h00);
      chk("t3_nvld", 32'(n_vld - v0), 32'd2);

      // Abort at idx 9 by a fresh fs that starts frame 5A/C3.
      v0 = n_vld;
      e0 = n_err;
      send(8'h11, 8'h22, 0, 8);
      send(8'h5A, 8'hC3, 0, 0);
      chk("t4_err", 32'(bus.err), 32'h1);
      chk("t4_novld", 32'(bus.o_vld), 32'h0);
      chk("t4_hold_oa", 32'(bus.oa), 32'hFF);
      chk("t4_hold_ob", 32'(bus.ob), 32'h00);
      send(8'h5A, 8'hC3, 1, 15);
      chk("t4_oa", 32'(bus.oa), 32'h5A);
      chk("t4_ob", 32'(bus.ob), 32'hC3);
      chk("t4_nvld", 32'(n_vld - v0), 32'd1);
      chk("t4_nerr", 32'(n_err - e0), 32'd1);

      // Reset at idx 7 while fs is presented; reset wins.
      send(8'h77, 8'h66, 0, 6);
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      chk("t6_oa", 32'(bus.oa), 32'h0);
      chk("t6_ob", 32'(bus.ob), 32'h0);
      chk("t6_vld", 32'(bus.o_vld), 32'h0);
      chk("t6_err", 32'(bus.err), 32'h0);
      v0 = n_vld;
      e0 = n_err;
      send(8'h12, 8'h34, 0, 15);
      chk("t6_oa2", 32'(bus.oa), 32'h12);
      chk("t6_ob2", 32'(bus.ob), 32'h34);
      chk("t6_nvld", 32'(n_vld - v0), 32'd1);
      chk("t6_nerr", 32'(n_err - e0), 32'd0);

      // Random bits without fs after reset: nothing may come out.
      rst = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      v0 = n_vld;
      e0 = n_err;
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
      end
      chk("t5_nvld", 32'(n_vld - v0), 32'd0);
      chk("t5_nerr", 32'(n_err - e0), 32'd0);
      chk("t5_oa", 32'(bus.oa), 32'h0);
      chk("t5_ob", 32'(bus.ob), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
